// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the 2-input gate response checker.
// Truth tables are indexed by {a,b}: bit 0 is the 00 vector, bit 3 is 11.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } chk_state_e;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;

   function automatic logic [1:0] vec_idx(input logic a, input logic b);
      return {a, b};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at its all-ones maximum.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/gate_truth_checker.sv
// Checks sampled 2-input gate responses against a truth table, tracking mismatches
// and input coverage; gives a pass/fail verdict once all four vectors are seen.
module gate_truth_checker
   import gate_chk_pkg::*;
#(
   parameter logic [3:0]  TRUTH = TT_AND,
   parameter int unsigned ERR_W = 8
) (
   input  logic             IN_clk,
   input  logic             IN_rst,
   input  logic             IN_start,
   input  logic             IN_valid,
   input  logic             IN_a,
   input  logic             IN_b,
   input  logic             IN_x,
   output logic             OUT_busy,
   output logic             OUT_done,
   output logic             OUT_pass,
   output logic             OUT_mismatch,
   output logic [ERR_W-1:0] OUT_err_cnt,
   output logic [3:0]       OUT_cov
);

   chk_state_e state_q;
   logic [1:0] idx;
   logic       expected;
   logic       mismatch;
   logic       accept;
   logic [3:0] cov_nxt;

   // Start takes priority over a coincident sample, so the sample never counts.
   always_comb begin
      idx      = vec_idx(IN_a, IN_b);
      expected = TRUTH[idx];
      mismatch = (IN_x != expected);
      accept   = (state_q == StRun) && IN_valid && !IN_start;
      cov_nxt  = OUT_cov | (4'b0001 << idx);
   end

   sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk (IN_clk),
      .rst (IN_rst),
      .clr (IN_start),
      .inc (accept && mismatch),
      .cnt (OUT_err_cnt)
   );

   always_ff @(posedge IN_clk or posedge IN_rst) begin
      if (IN_rst) begin
         state_q      <= StIdle;
         OUT_busy     <= 1'b0;
         OUT_done     <= 1'b0;
         OUT_pass     <= 1'b0;
         OUT_mismatch <= 1'b0;
         OUT_cov      <= '0;
      end else begin
         OUT_mismatch <= 1'b0;
         if (IN_start) begin
            state_q  <= StRun;
            OUT_busy <= 1'b1;
            OUT_done <= 1'b0;
            OUT_pass <= 1'b0;
            OUT_cov  <= '0;
         end else begin
            unique case (state_q)
               StRun: begin
                  if (IN_valid) begin
                     OUT_cov      <= cov_nxt;
                     OUT_mismatch <= mismatch;
                     if (cov_nxt == 4'hF) begin
                        // The counter has not absorbed this sample yet, so fold it in here.
                        state_q  <= StDone;
                        OUT_busy <= 1'b0;
                        OUT_done <= 1'b1;
                        OUT_pass <= (OUT_err_cnt == '0) && !mismatch;
                     end
                  end
               end
               StIdle, StDone: ;
               default: begin
                  state_q  <= StIdle;
                  OUT_busy <= 1'b0;
                  OUT_done <= 1'b0;
                  OUT_pass <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Self-checking bench: an AND checker (ERR_W 8) and an XOR checker (ERR_W 2)
// driven by directed and random samples, compared against a set-based reference model.
module tb_gate_truth_checker;
   import gate_chk_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic st[2], vl[2], ia[2], ib[2], ix[2];
   logic busy[2], done[2], pass[2], mism[2];
   logic [3:0] cov[2];
   logic [7:0] cnt0;
   logic [1:0] cnt1;

   gate_truth_checker #(.TRUTH(TT_AND), .ERR_W(8)) dut_and (
      .IN_clk(clk), .IN_rst(rst), .IN_start(st[0]), .IN_valid(vl[0]),
      .IN_a(ia[0]), .IN_b(ib[0]), .IN_x(ix[0]),
      .OUT_busy(busy[0]), .OUT_done(done[0]), .OUT_pass(pass[0]),
      .OUT_mismatch(mism[0]), .OUT_err_cnt(cnt0), .OUT_cov(cov[0])
   );

   gate_truth_checker #(.TRUTH(TT_XOR), .ERR_W(2)) dut_xor (
      .IN_clk(clk), .IN_rst(rst), .IN_start(st[1]), .IN_valid(vl[1]),
      .IN_a(ia[1]), .IN_b(ib[1]), .IN_x(ix[1]),
      .OUT_busy(busy[1]), .OUT_done(done[1]), .OUT_pass(pass[1]),
      .OUT_mismatch(mism[1]), .OUT_err_cnt(cnt1), .OUT_cov(cov[1])
   );

   // Reference model: a run is "open" until every vector has been seen at least once.
   bit m_run[2], m_fin[2], m_mis[2];
   bit m_seen[2][4];
   int m_err[2];
   int n_pass = 0;
   int n_total = 0;
   int pulses;

   function automatic bit gate_out(input int d, input bit a, input bit b);
      case (d)
         0:       return a & b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic int sat_max(input int d);
      return (d == 0) ? 255 : 3;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_run[d] = 0; m_fin[d] = 0; m_mis[d] = 0; m_err[d] = 0;
         for (int i = 0; i < 4; i++) m_seen[d][i] = 0;
      end
   endtask

   task automatic model_update(input int d);
      int k;
      m_mis[d] = 0;
      if (st[d]) begin
         m_run[d] = 1; m_fin[d] = 0; m_err[d] = 0;
         for (int i = 0; i < 4; i++) m_seen[d][i] = 0;
      end else if (m_run[d] && vl[d]) begin
         k = 2 * int'(ia[d]) + int'(ib[d]);
         if (ix[d] != gate_out(d, ia[d], ib[d])) begin
            m_err[d]++;
            m_mis[d] = 1;
         end
         m_seen[d][k] = 1;
         if (m_seen[d][0] && m_seen[d][1] && m_seen[d][2] && m_seen[d][3]) begin
            m_run[d] = 0;
            m_fin[d] = 1;
         end
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic check_dut(input int d);
      int c, e, cv;
      c  = (d == 0) ? int'(cnt0) : int'(cnt1);
      e  = (m_err[d] > sat_max(d)) ? sat_max(d) : m_err[d];
      cv = 8 * int'(m_seen[d][3]) + 4 * int'(m_seen[d][2]) + 2 * int'(m_seen[d][1])
         + int'(m_seen[d][0]);
      chk($sformatf("busy%0d", d), int'(busy[d]), int'(m_run[d]));
      chk($sformatf("done%0d", d), int'(done[d]), int'(m_fin[d]));
      chk($sformatf("pass%0d", d), int'(pass[d]), int'(m_fin[d] && m_err[d] == 0));
      chk($sformatf("mismatch%0d", d), int'(mism[d]), int'(m_mis[d]));
      chk($sformatf("err_cnt%0d", d), c, e);
      chk($sformatf("cov%0d", d), int'(cov[d]), cv);
   endtask

   task automatic step(input int d, input bit s, input bit v, input bit a, input bit b,
                       input bit x);
      @(negedge clk);
      st[d] = s; vl[d] = v; ia[d] = a; ib[d] = b; ix[d] = x;
      @(posedge clk);
      model_update(d);
      #1;
      check_dut(d);
      if (mism[d]) pulses++;
      st[d] = 0; vl[d] = 0;
   endtask

   initial begin
      bit a, b, x;
      int d;
      for (int i = 0; i < 2; i++) begin
         st[i] = 0; vl[i] = 0; ia[i] = 0; ib[i] = 0; ix[i] = 0;
      end
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_dut(0);
      check_dut(1);
      @(negedge clk);
      rst = 1'b0;

      // Correct AND in order.
      pulses = 0;
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 1, 1);
      chk("and_done", int'(done[0]), 1);
      chk("and_pass", int'(pass[0]), 1);
      chk("and_cov", int'(cov[0]), 15);
      chk("and_pulses", pulses, 0);

      // Faulty gate: 10 observed as 1.
      pulses = 0;
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);
      step(0, 0, 1, 1, 0, 1);
      chk("fault_pulse", int'(mism[0]), 1);
      step(0, 0, 1, 1, 1, 1);
      chk("fault_cnt", int'(cnt0), 1);
      chk("fault_pass", int'(pass[0]), 0);
      chk("fault_pulses", pulses, 1);

      // Repeats and gaps; samples in DONE are ignored.
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 1, 1);
      step(0, 0, 1, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);
      chk("rep_not_done", int'(done[0]), 0);
      step(0, 0, 1, 1, 0, 0);
      chk("rep_done", int'(done[0]), 1);
      chk("rep_cnt", int'(cnt0), 1);
      step(0, 0, 1, 0, 0, 1);

      // Restart mid-run with a coincident sample.
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 1);
      step(0, 0, 1, 0, 1, 0);
      step(0, 1, 1, 1, 1, 0);
      chk("restart_cnt", int'(cnt0), 0);
      chk("restart_cov", int'(cov[0]), 0);

      // Saturation on the XOR checker with ERR_W 2.
      pulses = 0;
      step(1, 1, 0, 0, 0, 0);
      repeat (5) step(1, 0, 1, 0, 0, 1);
      step(1, 0, 1, 0, 1, 1);
      step(1, 0, 1, 1, 0, 1);
      step(1, 0, 1, 1, 1, 0);
      chk("sat_cnt", int'(cnt1), 3);
      chk("sat_pulses", pulses, 5);
      chk("sat_done", int'(done[1]), 1);
      chk("sat_pass", int'(pass[1]), 0);

      // Asynchronous reset between edges, then samples without a start.
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 1);
      step(0, 0, 1, 1, 1, 1);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check_dut(0);
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 1, 0, 1, 1);
      step(0, 0, 1, 0, 0, 0);

      // Random traffic on both checkers.
      for (int n = 0; n < 600; n++) begin
         d = $urandom_range(0, 1);
         a = 1'($urandom_range(0, 1));
         b = 1'($urandom_range(0, 1));
         x = gate_out(d, a, b) ^ ($urandom_range(0, 4) == 0);
         step(d, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, a, b, x);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
